// File: rtl/cevero_mem_arbiter.sv
// Two-to-one instr/data arbiter onto a single req/gnt/rvalid memory port with an in-order source-ID FIFO.
// Optional macro CEVERO_ARB_RR_EN selects round-robin arbitration; the default is fixed data-over-instr priority.
module cevero_mem_arbiter #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   instr_req_i,
  output logic                   instr_gnt_o,
  output logic                   instr_rvalid_o,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  output logic [DataWidth-1:0]   instr_rdata_o,

  input  logic                   data_req_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  input  logic                   data_we_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  output logic [DataWidth-1:0]   data_rdata_o,

  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic [DataWidth-1:0]   mem_rdata_i,

  output logic                   protocol_err_o
);

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic            lock_q;
  src_e            lock_sel_q;
  src_e            policy_sel;
  src_e            sel;
  logic            sel_req;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  src_e            head;
  src_e            ids_q [MaxOutstanding];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [CntW-1:0] count_q;
  logic            err_q;

  assign full  = (count_q == CntW'(MaxOutstanding));
  assign empty = (count_q == '0);

`ifdef CEVERO_ARB_RR_EN
  src_e last_q;

  always_comb begin
    policy_sel = SRC_INSTR;
    if (instr_req_i && data_req_i) begin
      policy_sel = (last_q == SRC_DATA) ? SRC_INSTR : SRC_DATA;
    end else if (data_req_i) begin
      policy_sel = SRC_DATA;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= SRC_INSTR;
    end else if (push) begin
      last_q <= sel;
    end
  end
`else
  always_comb begin
    policy_sel = SRC_INSTR;
    if (data_req_i) begin
      policy_sel = SRC_DATA;
    end
  end
`endif

  assign sel       = lock_q ? lock_sel_q : policy_sel;
  assign sel_req   = (sel == SRC_DATA) ? data_req_i : instr_req_i;
  assign mem_req_o = sel_req & ~full;
  assign push      = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & ~empty;
  assign head      = ids_q[rptr_q];

  assign instr_gnt_o = push & (sel == SRC_INSTR);
  assign data_gnt_o  = push & (sel == SRC_DATA);

  assign instr_rvalid_o = pop & (head == SRC_INSTR);
  assign data_rvalid_o  = pop & (head == SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign protocol_err_o = err_q;

  // Attributes follow the selected requester even while stalled on a full FIFO, so a held lock keeps them stable.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (sel_req) begin
      if (sel == SRC_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = '1;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_sel_q <= SRC_INSTR;
    end else if (mem_req_o) begin
      lock_q     <= ~mem_gnt_i;
      lock_sel_q <= sel;
    end else if (!full) begin
      lock_q     <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        ids_q[i] <= SRC_INSTR;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        ids_q[wptr_q] <= sel;
        wptr_q        <= (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (mem_rvalid_i && empty) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cevero_mem_arbiter.sv
// Directed self-checking bench for cevero_mem_arbiter (default parameters, MaxOutstanding = 2).
module tb_cevero_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req, instr_gnt, instr_rvalid;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_gnt, mem_rvalid, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        perr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cevero_mem_arbiter #(.AddrWidth(32), .DataWidth(32), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .protocol_err_o(perr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the edge, checks happen 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req = 0; instr_addr = '0;
    data_req = 0; data_we = 0; data_be = '0; data_addr = '0; data_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic chk_grants(input string tag, input logic ig, input logic dg);
    chk({tag, "_ignt"}, {31'd0, instr_gnt}, {31'd0, ig});
    chk({tag, "_dgnt"}, {31'd0, data_gnt}, {31'd0, dg});
  endtask

  task automatic chk_rvalids(input string tag, input logic ir, input logic dr);
    chk({tag, "_irv"}, {31'd0, instr_rvalid}, {31'd0, ir});
    chk({tag, "_drv"}, {31'd0, data_rvalid}, {31'd0, dr});
  endtask

  logic [4:0] exp_dsel;

  initial begin
    idle_inputs();
    rst_n = 0;
    #12;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk_grants("rst", 0, 0);
    chk_rvalids("rst", 0, 0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_perr", {31'd0, perr}, 32'd0);
    tick();
    rst_n = 1;
    tick();

    // Instruction-only fetches, sp_ram style response one cycle after grant
    instr_req = 1; instr_addr = 32'h0; mem_gnt = 1;
    #1;
    chk_grants("f0", 1, 0);
    chk("f0_addr", mem_addr, 32'h0);
    chk("f0_be", {28'd0, mem_be}, 32'hF);
    chk("f0_we", {31'd0, mem_we}, 32'd0);
    tick();
    instr_addr = 32'h4; mem_rvalid = 1; mem_rdata = 32'hA000_0000;
    #1;
    chk_grants("f1", 1, 0);
    chk("f1_addr", mem_addr, 32'h4);
    chk_rvalids("f1", 1, 0);
    chk("f1_rdata", instr_rdata, 32'hA000_0000);
    tick();
    instr_addr = 32'h8; mem_rdata = 32'hA000_0004;
    #1;
    chk_grants("f2", 1, 0);
    chk("f2_addr", mem_addr, 32'h8);
    chk_rvalids("f2", 1, 0);
    chk("f2_rdata", instr_rdata, 32'hA000_0004);
    tick();
    instr_req = 0; mem_gnt = 0; mem_rdata = 32'hA000_0008;
    #1;
    chk("f3_req", {31'd0, mem_req}, 32'd0);
    chk_rvalids("f3", 1, 0);
    chk("f3_rdata", instr_rdata, 32'hA000_0008);
    tick();
    idle_inputs();

    // Conflict: instr 0x10 vs data read 0x100, then data drops in cycle 4
`ifdef CEVERO_ARB_RR_EN
    exp_dsel = 5'b00101;  // bit k: data granted in cycle k (D,I,D,I,I)
`else
    exp_dsel = 5'b01111;  // D,D,D,D,I
`endif
    instr_req = 1; instr_addr = 32'h10;
    data_req = 1; data_addr = 32'h100; data_be = 4'hF;
    mem_gnt = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) data_req = 0;
      mem_rvalid = (k > 0);
      #1;
      chk_grants($sformatf("arb%0d", k), ~exp_dsel[k], exp_dsel[k]);
      chk($sformatf("arb%0d_addr", k), mem_addr, exp_dsel[k] ? 32'h100 : 32'h10);
      if (k > 0) chk_rvalids($sformatf("arb%0d", k), ~exp_dsel[k-1], exp_dsel[k-1]);
      tick();
    end
    instr_req = 0; mem_gnt = 0; mem_rvalid = 1;
    #1;
    chk_rvalids("arb5", 1, 0);
    tick();
    idle_inputs();

    // Grant withheld for 3 cycles: data address must stay on the bus and win first
    instr_req = 1; instr_addr = 32'h10;
    data_req = 1; data_addr = 32'h200; data_be = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d_addr", k), mem_addr, 32'h200);
      chk($sformatf("hold%0d_req", k), {31'd0, mem_req}, 32'd1);
      chk_grants($sformatf("hold%0d", k), 0, 0);
      tick();
    end
    mem_gnt = 1;
    #1;
    chk_grants("hold3", 0, 1);
    chk("hold3_addr", mem_addr, 32'h200);
    tick();
    data_req = 0; mem_rvalid = 1;
    #1;
    chk_grants("hold4", 1, 0);
    chk_rvalids("hold4", 0, 1);
    tick();
    instr_req = 0; mem_gnt = 0;
    #1;
    chk_rvalids("hold5", 1, 0);
    tick();
    idle_inputs();

    // FIFO full: two outstanding, third stalled until first response (4 cycles late)
    instr_req = 1; instr_addr = 32'h20; mem_gnt = 1;
    #1;
    chk_grants("mo0", 1, 0);
    tick();
    instr_req = 0; data_req = 1; data_addr = 32'h300; data_be = 4'hF;
    #1;
    chk_grants("mo1", 0, 1);
    tick();
    data_req = 0; instr_req = 1; instr_addr = 32'h24;
    #1;
    chk("mo2_req", {31'd0, mem_req}, 32'd0);
    chk_grants("mo2", 0, 0);
    tick();
    #1;
    chk("mo3_req", {31'd0, mem_req}, 32'd0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    #1;
    chk("mo4_req", {31'd0, mem_req}, 32'd0);
    chk_rvalids("mo4", 1, 0);
    chk("mo4_rdata", instr_rdata, 32'h1111_2222);
    tick();
    mem_rdata = 32'h3333_4444;
    #1;
    chk("mo5_req", {31'd0, mem_req}, 32'd1);
    chk("mo5_addr", mem_addr, 32'h24);
    chk_grants("mo5", 1, 0);
    chk_rvalids("mo5", 0, 1);
    chk("mo5_rdata", data_rdata, 32'h3333_4444);
    tick();
    instr_req = 0; mem_gnt = 0;
    #1;
    chk_rvalids("mo6", 1, 0);
    tick();
    idle_inputs();

    // Data write with partial byte enables
    data_req = 1; data_we = 1; data_be = 4'b0011; data_addr = 32'h400;
    data_wdata = 32'hDEAD_BEEF; mem_gnt = 1;
    #1;
    chk_grants("wr", 0, 1);
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    chk("wr_be", {28'd0, mem_be}, 32'h3);
    chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr_addr", mem_addr, 32'h400);
    tick();
    idle_inputs();
    mem_rvalid = 1;
    #1;
    chk_rvalids("wr_done", 0, 1);
    chk("wr_perr", {31'd0, perr}, 32'd0);
    tick();
    idle_inputs();

    // Stray response with empty FIFO
    mem_rvalid = 1;
    #1;
    chk_rvalids("stray", 0, 0);
    tick();
    mem_rvalid = 0;
    #1;
    chk("stray_perr", {31'd0, perr}, 32'd1);
    tick(); tick();
    chk("stray_perr_sticky", {31'd0, perr}, 32'd1);
    rst_n = 0;
    #1;
    chk("stray_perr_rst", {31'd0, perr}, 32'd0);
    tick();
    rst_n = 1;
    tick();

    // Reset with a transaction outstanding; its late response must be flagged
    instr_req = 1; instr_addr = 32'h30; mem_gnt = 1;
    #1;
    chk_grants("rmid", 1, 0);
    tick();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    mem_rvalid = 1;
    #1;
    chk_rvalids("late", 0, 0);
    tick();
    mem_rvalid = 0;
    #1;
    chk("late_perr", {31'd0, perr}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cevero_mem_arbiter.md
# cevero_mem_arbiter

Two-to-one arbiter that shares a single `sp_ram`-style req/gnt/rvalid memory port between the fault-tolerant core's instruction and data interfaces. It sits between `cevero_ft_core` and one unified memory in `cevero_soc`. It selects one requester per cycle, holds that selection until the memory grants, and records the source of every granted transaction in an in-order ID FIFO. Each `mem_rvalid_i` is routed back to the requester that issued it.

## Interface
- `AddrWidth`, 32, address width of all ports
- `DataWidth`, 32, data width of all ports
- `MaxOutstanding`, 2, depth of the source-ID FIFO, i.e. maximum granted-but-not-returned transactions (≥1)

Ports:
- `clk_i`  in  1  single clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `instr_req_i` / `instr_gnt_o` / `instr_rvalid_o`  in/out/out  1 each  instruction-side handshake
- `instr_addr_i`  in  AddrWidth  fetch address
- `instr_rdata_o`  out  DataWidth  fetch data
- `data_req_i` / `data_gnt_o` / `data_rvalid_o`  in/out/out  1 each  data-side handshake
- `data_we_i`  in  1  write enable
- `data_be_i`  in  DataWidth/8  byte enables
- `data_addr_i`  in  AddrWidth  data address
- `data_wdata_i`  in  DataWidth  write data
- `data_rdata_o`  out  DataWidth  read data
- `mem_req_o`  out  1  request to memory
- `mem_gnt_i`  in  1  grant from memory
- `mem_rvalid_i`  in  1  response from memory
- `mem_we_o`  out  1  write enable to memory
- `mem_be_o`  out  DataWidth/8  byte enables to memory
- `mem_addr_o`  out  AddrWidth  address to memory
- `mem_wdata_o`  out  DataWidth  write data to memory
- `mem_rdata_i`  in  DataWidth  read data from memory
- `protocol_err_o`  out  1  sticky flag; set when `mem_rvalid_i` arrives with the FIFO empty

## Operation
- Selection (`sel`): `sel` is instr or data.
  - A `lock` register holds `sel` while `mem_req_o`=1 and `mem_gnt_i`=0, so address and attributes stay stable until granted.
  - With no lock, `sel` comes from the arbitration policy (see Configuration).
  - A lone requester always wins.
- Issue:
  - `mem_req_o` = selected requester's req AND `count < MaxOutstanding`.
  - Memory-side muxing of addr, we, be and wdata follows `sel`.
  - Instruction side drives `we`=0, `be`=all ones, `wdata`=0.
- Grant: only the selected requester's gnt is asserted, equal to `mem_gnt_i & mem_req_o`. Unselected gnt is 0.
- ID FIFO:
  - Circular buffer of 1-bit source IDs with write pointer, read pointer and `count`. Pointers wrap modulo `MaxOutstanding`.
  - Push on `mem_req_o & mem_gnt_i`.
  - Pop on `mem_rvalid_i` when `count` > 0.
  - Push and pop in the same cycle leave `count` unchanged.
  - Full: `mem_req_o` is forced to 0 and both gnt outputs are 0. The lock is kept if it was already set.
  - Empty with `mem_rvalid_i`=1: no pop, no requester rvalid, `protocol_err_o` sets. It is cleared only by reset.
- Response:
  - `instr_rvalid_o` = `mem_rvalid_i` & (head == instr); `data_rvalid_o` likewise for data.
  - Both rdata outputs are driven by `mem_rdata_i`.

## Timing
- Request-to-`mem_req_o`, `mem_gnt_i`-to-requester gnt and `mem_rvalid_i`-to-requester rvalid are all combinational, adding zero latency. Arbitration state is registered.
- The arbiter adds no bubbles. Back-to-back grants are possible every cycle until the FIFO is full.
- A response may arrive in the cycle after its grant (sp_ram behaviour) or later. Responses must be in order.
- Reset values:
  - All gnt/rvalid/req outputs 0.
  - `mem_we_o`=0, `mem_be_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0 while idle.
  - `protocol_err_o`=0, FIFO empty, lock clear, round-robin last-grant = instr.
- Reset mid-operation discards outstanding IDs. Late rvalids after reset release raise `protocol_err_o`.

## Configuration
- `CEVERO_ARB_RR_EN` defined: round-robin.
  - On conflict, grant the requester not granted last.
  - Last-grant updates only on an actual grant (`mem_req_o & mem_gnt_i`).
  - After reset, data wins the first conflict.
- Undefined: fixed priority, data over instr on every conflict. No last-grant register is built.

## Test plan
- Instr-only fetches at 0x0, 0x4, 0x8 with an sp_ram model: three gnts in consecutive cycles, three `instr_rvalid_o` one cycle later with matching data, `data_rvalid_o` stays 0.
- Simultaneous instr 0x10 and data read 0x100, repeated for 4 cycles:
  - With `CEVERO_ARB_RR_EN`: grants alternate D,I,D,I.
  - Without it: D,D,D,D, and instr is granted only after data deasserts.
- Memory withholds `mem_gnt_i` for 3 cycles while data holds 0x200 and instr also requests: `mem_addr_o` stays 0x200 throughout, and data is granted first.
- `MaxOutstanding`=2, memory delays rvalid by 4 cycles:
  - The third request is stalled with `mem_req_o`=0.
  - The first rvalid pops the FIFO and the third request is then granted.
  - rvalids route as I, D in issue order.
- Data write 0xDEADBEEF, be=4'b0011: `mem_we_o`=1, `mem_be_o`=0011 on the grant cycle, and `data_rvalid_o` pulses on completion.
- Inject `mem_rvalid_i` with the FIFO empty: no requester rvalid and `protocol_err_o`=1 until `rst_ni` is asserted.
